// File: rtl/cache_types.sv
`default_nettype none
// =====================================================================
// cache_types : shared state encoding, geometry and line type for l1_cache
// Revision    : 1.0
// =====================================================================
package cache_types;

  localparam int NUM_SETS_DEF  = 8;
  localparam int LINE_BITS_DEF = 256;
  localparam int OFFSET_W      = 5;
  localparam int IDX_W         = $clog2(NUM_SETS_DEF);
  localparam int TAG_W         = 32 - OFFSET_W - IDX_W;

  typedef logic [LINE_BITS_DEF-1:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_FILL      = 2'd3
  } cache_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// =====================================================================
// cache_control : miss-handling FSM; emits handshake outputs and array strobes
// Revision      : 1.0
// =====================================================================
module cache_control
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_i,
  input  logic         is_write_i,
  input  logic         hit_i,
  input  logic         valid_i,
  input  logic         dirty_i,
  input  logic         pmem_resp_i,
  output cache_state_t state_o,
  output logic         mem_resp_o,
  output logic         pmem_read_o,
  output logic         pmem_write_o,
  output logic         load_line_o,
  output logic         clr_dirty_o,
  output logic         wr_hit_o
);

  cache_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp_o   = 1'b0;
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;
    load_line_o  = 1'b0;
    clr_dirty_o  = 1'b0;
    wr_hit_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit_i) begin
          mem_resp_o = 1'b1;
          wr_hit_o   = is_write_i;
          state_d    = S_IDLE;
        end else if (valid_i && dirty_i) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        pmem_write_o = 1'b1;
        if (pmem_resp_i) begin
          clr_dirty_o = 1'b1;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        pmem_read_o = 1'b1;
        // After the fill the request is re-evaluated in COMPARE, where it now hits.
        if (pmem_resp_i) begin
          load_line_o = 1'b1;
          state_d     = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/l1_cache.sv
`default_nettype none
// =====================================================================
// l1_cache : direct-mapped write-back/write-allocate cache, 32-bit cpu, 256-bit lines
// Revision : 1.0
// =====================================================================
module l1_cache
  import cache_types::*;
#(
  parameter int NUM_SETS  = NUM_SETS_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_address,
  input  logic [31:0]          mem_wdata,
  output logic                 mem_resp,
  output logic [31:0]          mem_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [LINE_BITS-1:0] pmem_rdata
);

  localparam int IW     = $clog2(NUM_SETS);
  localparam int TW     = 32 - OFFSET_W - IW;
  localparam int WSEL_W = $clog2(LINE_BITS / 32);

  logic [NUM_SETS-1:0]  valid_q, valid_d;
  logic [NUM_SETS-1:0]  dirty_q, dirty_d;
  logic [TW-1:0]        tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  logic [IW-1:0]        idx;
  logic [TW-1:0]        tag;
  logic [WSEL_W-1:0]    wsel;
  logic [LINE_BITS-1:0] cur_line, merged_line;
  logic [31:0]          cur_word;
  logic                 hit, resp, load_line, clr_dirty, wr_hit;
  cache_state_t         state;
  logic                 unused_addr_bits;

  assign idx              = mem_address[OFFSET_W +: IW];
  assign tag              = mem_address[31 -: TW];
  assign wsel             = mem_address[OFFSET_W-1 -: WSEL_W];
  assign unused_addr_bits = ^mem_address[1:0];

  assign cur_line = data_q[idx];
  assign cur_word = cur_line[{wsel, 5'd0} +: 32];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  cache_control u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (mem_read | mem_write),
    .is_write_i   (mem_write),
    .hit_i        (hit),
    .valid_i      (valid_q[idx]),
    .dirty_i      (dirty_q[idx]),
    .pmem_resp_i  (pmem_resp),
    .state_o      (state),
    .mem_resp_o   (resp),
    .pmem_read_o  (pmem_read),
    .pmem_write_o (pmem_write),
    .load_line_o  (load_line),
    .clr_dirty_o  (clr_dirty),
    .wr_hit_o     (wr_hit)
  );

  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_line[{wsel, 5'(b * 8)} +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  // Data and tags are deliberately left out of reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx] <= merged_line;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (load_line) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (clr_dirty) dirty_d[idx] = 1'b0;
    if (wr_hit)    dirty_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      S_WRITEBACK: begin
        pmem_address = {tag_q[idx], idx, {OFFSET_W{1'b0}}};
        pmem_wdata   = cur_line;
      end
      S_FILL:  pmem_address = {mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
      default: ;
    endcase
  end

  assign mem_resp  = resp;
  assign mem_rdata = resp ? cur_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_l1_cache.sv
`default_nettype none
// =====================================================================
// tb_l1_cache : vector table, directed corner sequences and random traffic
// Revision    : 1.0
// =====================================================================
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
  );

  int checks = 0, failures = 0, viol = 0;
  int lat = 3;
  int n_rd = 0, n_wr = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0;

  logic [255:0] pmem_m [logic [26:0]];
  logic [31:0]  ref_m  [logic [29:0]];
  bit           mv [8];
  bit           md [8];
  logic [23:0]  mt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {5'(w), la};
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [26:0] la);
    if (pmem_m.exists(la)) return pmem_m[la];
    return init_line(la);
  endfunction

  // CPU-visible memory: latest written word, else whatever backing memory holds.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [255:0] l;
    if (ref_m.exists(a[31:2])) return ref_m[a[31:2]];
    l = line_of(a[31:5]);
    return l[int'(a[4:2])*32 +: 32];
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_m[a[31:2]] = w;
  endfunction

  // Expected cycles-to-response, from which lines are resident and dirty.
  function automatic int model_access(input bit wr, input logic [31:0] a, input int l);
    int i, c;
    i = int'(a[7:5]);
    if (mv[i] && mt[i] == a[31:8]) c = 2;
    else begin
      c = (mv[i] && md[i]) ? 3 + 2*l : 3 + l;
      mv[i] = 1'b1; mt[i] = a[31:8]; md[i] = 1'b0;
    end
    if (wr) md[i] = 1'b1;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    ref_m.delete();
  endfunction

  // Backing memory: answers after 'lat' cycles of a held request.
  initial begin : responder
    int cnt;
    logic [31:0] held;
    cnt = 0; held = 0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp && (pmem_read || pmem_write)) viol++;
      if (rst_n && (pmem_read || pmem_write)) begin
        if (pmem_read && pmem_write) viol++;
        if (pmem_address[4:0] != 5'd0) viol++;
        if (cnt > 0 && pmem_address !== held) viol++;
        held = pmem_address;
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata = line_of(pmem_address[31:5]);
            last_rd_addr = pmem_address;
            n_rd++;
          end else begin
            pmem_m[pmem_address[31:5]] = pmem_wdata;
            last_wr_addr = pmem_address;
            n_wr++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output int cyc,
                        output int drd, output int dwr);
    int r0, w0;
    r0 = n_rd; w0 = n_wr;
    @(posedge clk); #1;
    mem_read = !wr || both; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_resp && cyc < 300);
    rd = mem_rdata;
    if (!mem_resp) check("access_timeout", {31'd0, mem_resp}, 32'd1);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    drd = n_rd - r0; dwr = n_wr - w0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_prd;
    int          exp_pwr;
    logic [31:0] exp_fill_addr;
    logic [31:0] exp_wb_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin : main
    logic [255:0] l;
    logic [31:0]  rd, a, d, er;
    logic [3:0]   be;
    int           cyc, drd, dwr, el, to;
    bit           wr, both;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'h0; mem_address = 32'h0; mem_wdata = 32'h0;
    model_reset();
    l = init_line(27'd8);  l[63:32] = 32'hDEADBEEF; pmem_m[27'd8]  = l;
    l = init_line(27'd16); l[63:32] = 32'hCAFE0204; pmem_m[27'd16] = l;

    // lat = 3 throughout the table
    vecs[0] = '{1'b0, 32'h104, 32'h0,        4'h0, 32'hDEADBEEF, 6, 1, 0, 32'h100, 32'h0};
    vecs[1] = '{1'b0, 32'h104, 32'h0,        4'h0, 32'hDEADBEEF, 2, 0, 0, 32'h0,   32'h0};
    vecs[2] = '{1'b1, 32'h104, 32'h11223344, 4'h3, 32'h0,        2, 0, 0, 32'h0,   32'h0};
    vecs[3] = '{1'b0, 32'h104, 32'h0,        4'h0, 32'hDEAD3344, 2, 0, 0, 32'h0,   32'h0};
    vecs[4] = '{1'b0, 32'h204, 32'h0,        4'h0, 32'hCAFE0204, 9, 1, 1, 32'h200, 32'h100};
    vecs[5] = '{1'b0, 32'h104, 32'h0,        4'h0, 32'hDEAD3344, 6, 1, 0, 32'h100, 32'h0};
    vecs[6] = '{1'b1, 32'h13C, 32'hFFFFFFFF, 4'h0, 32'h0,        6, 1, 0, 32'h120, 32'h0};
    vecs[7] = '{1'b0, 32'h13C, 32'h0,        4'h0, 32'h38000009, 2, 0, 0, 32'h0,   32'h0};
    vecs[8] = '{1'b0, 32'h33C, 32'h0,        4'h0, 32'h38000019, 9, 1, 1, 32'h320, 32'h120};

    repeat (3) @(negedge clk);
    check("rst_mem_resp",  {31'd0, mem_resp},  32'd0);
    check("rst_pmem_rw",   {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst_pmem_addr", pmem_address, 32'd0);
    check("rst_rdata",     mem_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_pmem_rw",  {30'd0, pmem_read, pmem_write}, 32'd0);

    for (int k = 0; k < 9; k++) begin
      el = model_access(vecs[k].wr, vecs[k].addr, lat);
      access(vecs[k].wr, 1'b0, vecs[k].addr, vecs[k].wdata, vecs[k].be, rd, cyc, drd, dwr);
      if (vecs[k].wr) ref_write(vecs[k].addr, vecs[k].wdata, vecs[k].be);
      else check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      check($sformatf("vec%0d_latency", k), 32'(cyc), 32'(vecs[k].exp_lat));
      check($sformatf("vec%0d_pmem_reads", k), 32'(drd), 32'(vecs[k].exp_prd));
      check($sformatf("vec%0d_pmem_writes", k), 32'(dwr), 32'(vecs[k].exp_pwr));
      if (vecs[k].exp_prd != 0) check($sformatf("vec%0d_fill_addr", k), last_rd_addr, vecs[k].exp_fill_addr);
      if (vecs[k].exp_pwr != 0) check($sformatf("vec%0d_wb_addr", k), last_wr_addr, vecs[k].exp_wb_addr);
      if (k == 4) begin
        l = pmem_m[27'd8];
        check("wb_line_word1", l[63:32], 32'hDEAD3344);
      end
    end

    // Dirty a line, then reset in the middle of an unrelated fill.
    el = model_access(1'b1, 32'h28, lat);
    access(1'b1, 1'b0, 32'h28, 32'h55AA55AA, 4'hF, rd, cyc, drd, dwr);
    ref_write(32'h28, 32'h55AA55AA, 4'hF);
    check("pre_rst_wr_latency", 32'(cyc), 32'(el));
    access(1'b0, 1'b0, 32'h28, 32'h0, 4'h0, rd, cyc, drd, dwr);
    check("pre_rst_rdata", rd, 32'h55AA55AA);

    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h404;
    to = 0;
    while (!pmem_read && to < 20) begin @(posedge clk); #1; to++; end
    check("fill_started", {31'd0, pmem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_pmem_read", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst_pmem_addr_zero", pmem_address, 32'd0);
    mem_read = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    access(1'b0, 1'b0, 32'h204, 32'h0, 4'h0, rd, cyc, drd, dwr);
    el = model_access(1'b0, 32'h204, lat);
    check("post_rst_rdata", rd, 32'hCAFE0204);
    check("post_rst_miss_latency", 32'(cyc), 32'(3 + lat));
    check("post_rst_pmem_reads", 32'(drd), 32'd1);
    access(1'b0, 1'b0, 32'h28, 32'h0, 4'h0, rd, cyc, drd, dwr);
    el = model_access(1'b0, 32'h28, lat);
    check("lost_dirty_rdata", rd, 32'h10000001);
    check("lost_dirty_latency", 32'(cyc), 32'(el));

    // Memory stalls: request must be held steady with no cpu response.
    lat = 11;
    er = ref_read(32'h504);
    el = model_access(1'b0, 32'h504, lat);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h504;
    to = 0;
    while (!pmem_read && to < 20) begin @(posedge clk); #1; to++; end
    for (int i = 0; i < 10; i++) begin
      check("stall_read_held_no_resp", {30'd0, pmem_read, mem_resp}, 32'd2);
      check("stall_addr", pmem_address, 32'h500);
      @(posedge clk); #1;
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_resp && cyc < 40);
    check("stall_resp", {31'd0, mem_resp}, 32'd1);
    check("stall_rdata", mem_rdata, er);
    check("stall_rdata_const", mem_rdata, 32'h08000028);
    @(posedge clk); #1;
    mem_read = 1'b0;

    for (int n = 0; n < 150; n++) begin
      lat  = $urandom_range(1, 4);
      wr   = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 7) == 0);
      a    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
           | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
      d    = $urandom;
      be   = 4'($urandom_range(0, 15));
      er   = ref_read(a);
      el   = model_access(wr, a, lat);
      access(wr, both, a, d, be, rd, cyc, drd, dwr);
      if (wr) ref_write(a, d, be);
      else check($sformatf("rand%0d_rdata@%h", n, a), rd, er);
      check($sformatf("rand%0d_latency@%h", n, a), 32'(cyc), 32'(el));
    end

    check("pmem_protocol_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
